lfsr_sched: RTL and testbench
=============================

# lfsr_sched

Round-robin scheduler that shares one Galois LFSR datapath among R requesters. Each requester issues a DRAW (advance S steps, return word), LOAD (seed) or RESET (force all-ones) operation; the block arbitrates, sequences the LFSR's `ld`/`en`/`rst`/`sel0` controls and returns a one-hot response. It sits between the PRNG consumers and the LFSR instance and owns the tap configuration register.

## Interface
- `N`, 32: LFSR width; only 32 is supported, because the half-word mode returns bits [31:16].
- `R`, 4: number of requesters (2..8).
- `SW`, 6: step-count width per request.
- `TAPS_RST`, 32'h8020_0003: reset value of the tap register.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  R  request pending, held until accepted
- `req_op`  in  2R  per-requester op: 00 DRAW, 01 LOAD, 10 RESET, 11 reserved
- `req_seed`  in  N·R  LOAD seed
- `req_steps`  in  SW·R  DRAW step count
- `req_half`  in  R  1: return 16-bit word (`lfsr_sel0`=1)
- `req_ready`  out  R  one-hot accept pulse
- `resp_valid`  out  R  one-hot completion pulse, 1 cycle
- `resp_data`  out  N  result word, valid with `resp_valid`
- `resp_err`  out  1  reserved op, valid with `resp_valid`
- `cfg_we`  in  1  write `cfg_taps` into the tap register
- `cfg_taps`  in  N  new tap mask
- `busy`  out  1  FSM not in IDLE
- `lfsr_rst`, `lfsr_ld`, `lfsr_en`, `lfsr_sel0`, `lfsr_sel1`  out  1 each  LFSR controls; `lfsr_sel1` tied 0
- `lfsr_taps`  out  N  active tap mask
- `lfsr_seed`  out  N  LFSR load data
- `lfsr_q`  in  N  LFSR output word

## Operation
- FSM states: IDLE, LOAD, RST, STEP, CAPT.
- IDLE: if any `req_valid`, the arbiter grants requester g and pulses `req_ready[g]`.
- On the grant edge: latch op, seed, steps and half into working registers; copy the tap register into the active taps.
- Grant edge next-state: DRAW → STEP, or CAPT if steps=0; LOAD → LOAD; RESET → RST; op 11 → CAPT with the error flag set.
- LOAD: `lfsr_ld`=1 for one cycle, `lfsr_seed` = latched seed → CAPT.
- RST: `lfsr_rst`=1 for one cycle → CAPT.
- STEP: `lfsr_en`=1 each cycle; a counter decrements from the latched steps; on the last step → CAPT.
- CAPT: on the exit edge, `resp_data` ← `lfsr_q` and `resp_valid[g]` ← 1; next state IDLE.
- The result is a 32-bit word, or {16'd0, bits[31:16]} when half mode is selected.
- `lfsr_sel0` = latched half for the whole operation; 0 in IDLE.
- Round-robin pointer: holds the last granted index; search order is ptr+1 … ptr (mod R).
- Pointer reset value is R-1, so requester 0 wins first.
- The tap register is written on any `cfg_we`, busy or not. Only the active copy drives `lfsr_taps`, so a write never changes an operation in flight.
- Outputs held at 0 when not in the relevant state: `lfsr_ld`, `lfsr_en`, `lfsr_seed`.

## Timing
- All outputs are registered, except `req_ready` (combinational from IDLE and arbiter) and the LFSR strobes (decoded from registered state).
- Reset values: state IDLE, `resp_valid`=0, `resp_data`=0, `resp_err`=0, `busy`=0, ptr=R-1, taps=`TAPS_RST`.
- `lfsr_rst` also equals 1 in reset and during the first cycle after release, which forces the LFSR to all-ones.
- Latency (accept in cycle 0):
  - DRAW S≥1: STEP cycles 1..S, CAPT S+1, `resp_valid` in cycle S+2.
  - DRAW S=0: `resp_valid` in cycle 2.
  - LOAD, RESET: `resp_valid` in cycle 3.
  - Reserved op: `resp_valid` in cycle 2.
- `resp_valid` coincides with IDLE, so a new grant may occur in the same cycle (back-to-back).
- A requester dropping `req_valid` before acceptance is legal; request fields are sampled only on the grant edge.
- `rst_n` low mid-operation aborts at once: no `resp_valid`, the pending op is lost, the FSM returns to IDLE.

## Structure
- Package `lfsr_sched_pkg`:
  - op encoding constants `OP_DRAW`, `OP_LOAD`, `OP_RST`, `OP_RSVD`
  - FSM state enum
  - `TAPS_RST`
- Sub-module `rr_arbiter` (R-wide, pointer-based, one-hot grant output). Its pointer advances only on the accept strobe.

## Test plan
- Reset release → `lfsr_rst` high for one cycle after release. Then LOAD 32'h0000_0001 and DRAW S=1 with default taps → `resp_data`=32'h0000_0002.
- LOAD 32'h8000_0000, DRAW S=1 → `resp_data`=32'h8020_0003. With `req_half`=1 → 32'h0000_8020.
- All four `req_valid` held high, DRAW S=0 each → accepts 0,1,2,3,0; `resp_valid` spacing is 2 cycles.
- Op 11 from requester 2 → `resp_err`=1 with `resp_valid`=4'b0100, and no `lfsr_ld`/`lfsr_en`/`lfsr_rst` pulse.
- `cfg_we` with taps 32'h0000_0001 during a DRAW S=10 → `lfsr_taps` stays at the old value for that op. The next op uses 32'h0000_0001.
- `rst_n` pulsed low in STEP cycle 3 of S=20 → no `resp_valid`, `busy`=0, next grant goes to requester 0.

Source files
------------

// File: rtl/lfsr_sched_pkg.sv
// Shared encodings for the LFSR request scheduler: op codes, FSM states and
// the power-on tap mask.
package lfsr_sched_pkg;

    localparam logic [1:0] OP_DRAW = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_RST  = 3'd2;
    localparam state_t ST_STEP = 3'd3;
    localparam state_t ST_CAPT = 3'd4;

    localparam logic [31:0] TAPS_RST = 32'h8020_0003;

endpackage

// File: rtl/lfsr_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter: searches ptr+1 .. ptr (mod R) and
// remembers the last winner only when the grant is actually taken.
module rr_arbiter #(
    parameter int R  = 4,
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [R-1:0]  req,
    input  logic          accept,
    output logic [R-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        cand      = '0;
        found     = 1'b0;
        for (int i = 1; i <= R; i++) begin
            cand = PW'((int'(ptr) + i) % R);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Reset to R-1 so that requester 0 is first in the search order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PW'(R - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one Galois LFSR among R requesters; owns the
// tap register and sequences the LFSR load/step/reset strobes.
module lfsr_sched
    import lfsr_sched_pkg::*;
#(
    parameter int           N        = 32,
    parameter int           R        = 4,
    parameter int           SW       = 6,
    parameter logic [N-1:0] TAPS_RST = lfsr_sched_pkg::TAPS_RST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req_valid,
    input  logic [2*R-1:0]  req_op,
    input  logic [N*R-1:0]  req_seed,
    input  logic [SW*R-1:0] req_steps,
    input  logic [R-1:0]    req_half,
    output logic [R-1:0]    req_ready,
    output logic [R-1:0]    resp_valid,
    output logic [N-1:0]    resp_data,
    output logic            resp_err,
    input  logic            cfg_we,
    input  logic [N-1:0]    cfg_taps,
    output logic            busy,
    output logic            lfsr_rst,
    output logic            lfsr_ld,
    output logic            lfsr_en,
    output logic            lfsr_sel0,
    output logic            lfsr_sel1,
    output logic [N-1:0]    lfsr_taps,
    output logic [N-1:0]    lfsr_seed,
    input  logic [N-1:0]    lfsr_q
);

    localparam int PW = (R > 1) ? $clog2(R) : 1;

    state_t         state;
    logic [N-1:0]   taps_reg;
    logic [N-1:0]   taps_act;
    logic [N-1:0]   seed_q;
    logic [SW-1:0]  cnt;
    logic           half_q;
    logic           err_q;
    logic           rst_first;
    logic [PW-1:0]  gidx_q;

    logic [R-1:0]   grant;
    logic [PW-1:0]  grant_idx;
    logic           accept;
    logic [1:0]     g_op;
    logic [N-1:0]   g_seed;
    logic [SW-1:0]  g_steps;
    logic           g_half;

    assign accept = (state == ST_IDLE) && (|req_valid);

    rr_arbiter #(
        .R  (R),
        .PW (PW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        g_op    = req_op[int'(grant_idx)*2 +: 2];
        g_seed  = req_seed[int'(grant_idx)*N +: N];
        g_steps = req_steps[int'(grant_idx)*SW +: SW];
        g_half  = req_half[grant_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            seed_q     <= '0;
            cnt        <= '0;
            half_q     <= 1'b0;
            err_q      <= 1'b0;
            gidx_q     <= '0;
            taps_act   <= TAPS_RST;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        seed_q   <= g_seed;
                        cnt      <= g_steps;
                        half_q   <= g_half;
                        gidx_q   <= grant_idx;
                        err_q    <= (g_op == OP_RSVD);
                        taps_act <= taps_reg;
                        case (g_op)
                            OP_DRAW: state <= (g_steps == '0) ? ST_CAPT : ST_STEP;
                            OP_LOAD: state <= ST_LOAD;
                            OP_RST:  state <= ST_RST;
                            default: state <= ST_CAPT;
                        endcase
                    end
                end
                ST_LOAD, ST_RST: state <= ST_CAPT;
                ST_STEP: begin
                    cnt <= cnt - SW'(1);
                    if (cnt <= SW'(1)) begin
                        state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    // Half mode returns the upper half-word zero-extended.
                    resp_data  <= half_q ? {{(N-16){1'b0}}, lfsr_q[N-1:N-16]} : lfsr_q;
                    resp_valid <= R'(1) << gidx_q;
                    resp_err   <= err_q;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Staged tap mask: only the copy taken at grant time reaches the LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_reg  <= TAPS_RST;
            rst_first <= 1'b1;
        end else begin
            rst_first <= 1'b0;
            if (cfg_we) begin
                taps_reg <= cfg_taps;
            end
        end
    end

    assign req_ready = accept ? grant : '0;
    assign busy      = (state != ST_IDLE);
    assign lfsr_rst  = rst_first || (state == ST_RST);
    assign lfsr_ld   = (state == ST_LOAD);
    assign lfsr_en   = (state == ST_STEP);
    assign lfsr_sel0 = (state != ST_IDLE) && half_q;
    assign lfsr_sel1 = 1'b0;
    assign lfsr_taps = taps_act;
    assign lfsr_seed = (state == ST_LOAD) ? seed_q : '0;

endmodule

// File: tb/tb_lfsr_sched.sv
// Self-checking bench for lfsr_sched with a behavioural Galois LFSR on the
// far side and a scoreboard of expected responses.
module tb_lfsr_sched;
    import lfsr_sched_pkg::*;

    localparam int N  = 32;
    localparam int R  = 4;
    localparam int SW = 6;

    logic            clk;
    logic            rst_n;
    logic [R-1:0]    req_valid;
    logic [2*R-1:0]  req_op;
    logic [N*R-1:0]  req_seed;
    logic [SW*R-1:0] req_steps;
    logic [R-1:0]    req_half;
    logic [R-1:0]    req_ready;
    logic [R-1:0]    resp_valid;
    logic [N-1:0]    resp_data;
    logic            resp_err;
    logic            cfg_we;
    logic [N-1:0]    cfg_taps;
    logic            busy;
    logic            lfsr_rst, lfsr_ld, lfsr_en, lfsr_sel0, lfsr_sel1;
    logic [N-1:0]    lfsr_taps;
    logic [N-1:0]    lfsr_seed;
    logic [N-1:0]    lfsr_q;

    typedef struct packed {
        logic [R-1:0] rv;
        logic [N-1:0] data;
        logic         err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pred;
    logic [31:0] taps_model;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_ld = 0, n_en = 0, n_rst = 0, n_sel0 = 0;

    lfsr_sched #(
        .N        (N),
        .R        (R),
        .SW       (SW),
        .TAPS_RST (32'h8020_0003)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_seed   (req_seed),
        .req_steps  (req_steps),
        .req_half   (req_half),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .cfg_we     (cfg_we),
        .cfg_taps   (cfg_taps),
        .busy       (busy),
        .lfsr_rst   (lfsr_rst),
        .lfsr_ld    (lfsr_ld),
        .lfsr_en    (lfsr_en),
        .lfsr_sel0  (lfsr_sel0),
        .lfsr_sel1  (lfsr_sel1),
        .lfsr_taps  (lfsr_taps),
        .lfsr_seed  (lfsr_seed),
        .lfsr_q     (lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] gal(input logic [31:0] v, input logic [31:0] t);
        return {v[30:0], 1'b0} ^ (v[31] ? t : 32'h0);
    endfunction

    // Left-shifting Galois LFSR standing in for the real instance.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lfsr_rst)     lfsr_q <= 32'hFFFF_FFFF;
        else if (lfsr_ld) lfsr_q <= lfsr_seed;
        else if (lfsr_en) lfsr_q <= gal(lfsr_q, lfsr_taps);
        if (lfsr_ld)   n_ld   <= n_ld + 1;
        if (lfsr_en)   n_en   <= n_en + 1;
        if (lfsr_rst)  n_rst  <= n_rst + 1;
        if (lfsr_sel0) n_sel0 <= n_sel0 + 1;
    end

    task automatic issue(input int idx, input logic [1:0] op, input logic [31:0] seed,
                         input logic [SW-1:0] steps, input logic half);
        req_op[idx*2 +: 2]      = op;
        req_seed[idx*N +: N]    = seed;
        req_steps[idx*SW +: SW] = steps;
        req_half[idx]           = half;
        req_valid[idx]          = 1'b1;
    endtask

    task automatic push_expect(input int idx, input logic [1:0] op, input logic [31:0] seed,
                               input logic [SW-1:0] steps, input logic half);
        exp_t e;
        case (op)
            OP_DRAW: for (int s = 0; s < int'(steps); s++) pred = gal(pred, taps_model);
            OP_LOAD: pred = seed;
            OP_RST:  pred = 32'hFFFF_FFFF;
            default: ;
        endcase
        e.rv   = R'(1) << idx;
        e.data = half ? {16'h0, pred[31:16]} : pred;
        e.err  = (op == OP_RSVD);
        sb.push_back(e);
    endtask

    task automatic sb_pop(output exp_t e);
        if (sb.size() == 0) e = 'x;
        else e = sb.pop_front();
    endtask

    task automatic run_op(input int idx, input logic [1:0] op, input logic [31:0] seed,
                          input logic [SW-1:0] steps, input logic half,
                          output exp_t act, output int lat, output bit to);
        bit acc = 0;
        bit got = 0;
        int t0 = 0;
        to  = 0;
        lat = -1;
        act = 'x;
        @(negedge clk);
        issue(idx, op, seed, steps, half);
        for (int k = 0; k < 50 && !acc; k++) begin
            #1;
            if (req_ready[idx]) begin
                acc = 1;
                t0  = cyc;
                push_expect(idx, op, seed, steps, half);
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) begin
            req_valid[idx] = 1'b0;
            to = 1;
            return;
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            #1;
            if (|resp_valid) begin
                got      = 1;
                act.rv   = resp_valid;
                act.data = resp_data;
                act.err  = resp_err;
                lat      = cyc - t0;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) to = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (lfsr_rst !== 1'b1) $display("[TB] FAIL rst_lfsr_rst_in_reset: got %b expected 1", lfsr_rst); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (resp_valid !== '0 || resp_err !== 1'b0) $display("[TB] FAIL rst_resp: got rv=%b err=%b expected 0/0", resp_valid, resp_err); else n_pass++;
        n_checks++; if (resp_data !== 32'h0) $display("[TB] FAIL rst_resp_data: got %h expected 00000000", resp_data); else n_pass++;
        n_checks++; if (lfsr_taps !== 32'h8020_0003) $display("[TB] FAIL rst_taps: got %h expected 80200003", lfsr_taps); else n_pass++;
        n_checks++; if (lfsr_ld !== 1'b0 || lfsr_en !== 1'b0 || lfsr_sel0 !== 1'b0) $display("[TB] FAIL rst_strobes: got ld=%b en=%b sel0=%b expected 0", lfsr_ld, lfsr_en, lfsr_sel0); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (lfsr_rst !== 1'b1) $display("[TB] FAIL rst_lfsr_rst_after_release: got %b expected 1", lfsr_rst); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (lfsr_rst !== 1'b0) $display("[TB] FAIL rst_lfsr_rst_cleared: got %b expected 0", lfsr_rst); else n_pass++;
        pred       = 32'hFFFF_FFFF;
        taps_model = 32'h8020_0003;
        sb.delete();
    endtask

    task automatic test_draw();
        exp_t act, e;
        int   lat, en0;
        bit   to;
        run_op(0, OP_LOAD, 32'h0000_0001, 6'd0, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e) $display("[TB] FAIL load1_resp: got rv=%b data=%h err=%b expected rv=%b data=%h err=%b", act.rv, act.data, act.err, e.rv, e.data, e.err); else n_pass++;
        n_checks++; if (lat !== 3) $display("[TB] FAIL load_latency: got %0d expected 3", lat); else n_pass++;
        en0 = n_en;
        run_op(0, OP_DRAW, 32'h0, 6'd1, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e) $display("[TB] FAIL draw1_resp: got rv=%b data=%h err=%b expected rv=%b data=%h err=%b", act.rv, act.data, act.err, e.rv, e.data, e.err); else n_pass++;
        n_checks++; if (act.data !== 32'h0000_0002) $display("[TB] FAIL draw1_value: got %h expected 00000002", act.data); else n_pass++;
        n_checks++; if (lat !== 3 || (n_en - en0) !== 1) $display("[TB] FAIL draw1_timing: got lat=%0d en=%0d expected 3/1", lat, n_en - en0); else n_pass++;
        run_op(0, OP_DRAW, 32'h0, 6'd0, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e || lat !== 2) $display("[TB] FAIL draw0_resp: got data=%h lat=%0d expected data=%h lat=2", act.data, lat, e.data); else n_pass++;
        run_op(0, OP_LOAD, $urandom, 6'd0, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e) $display("[TB] FAIL load_rand_resp: got data=%h expected data=%h", act.data, e.data); else n_pass++;
        run_op(0, OP_DRAW, 32'h0, 6'd37, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e || lat !== 39) $display("[TB] FAIL draw37_resp: got data=%h lat=%0d expected data=%h lat=39", act.data, lat, e.data); else n_pass++;
    endtask

    task automatic test_half();
        exp_t act, e;
        int   lat, s0;
        bit   to;
        run_op(1, OP_LOAD, 32'h8000_0000, 6'd0, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e) $display("[TB] FAIL half_load_resp: got data=%h expected %h", act.data, e.data); else n_pass++;
        run_op(1, OP_DRAW, 32'h0, 6'd1, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e || act.data !== 32'h8020_0003) $display("[TB] FAIL full_word_value: got %h expected 80200003", act.data); else n_pass++;
        run_op(1, OP_LOAD, 32'h8000_0000, 6'd0, 1'b0, act, lat, to);
        sb_pop(e);
        s0 = n_sel0;
        run_op(1, OP_DRAW, 32'h0, 6'd1, 1'b1, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e || act.data !== 32'h0000_8020) $display("[TB] FAIL half_word_value: got %h expected 00008020", act.data); else n_pass++;
        n_checks++; if ((n_sel0 - s0) !== 2) $display("[TB] FAIL half_sel0_cycles: got %0d expected 2", n_sel0 - s0); else n_pass++;
    endtask

    task automatic test_reserved();
        exp_t act, e;
        int   lat, strobes0;
        bit   to;
        strobes0 = n_ld + n_en + n_rst;
        run_op(2, OP_RSVD, 32'h1234_5678, 6'd5, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e || act.rv !== 4'b0100 || act.err !== 1'b1) $display("[TB] FAIL rsvd_resp: got rv=%b err=%b data=%h expected rv=0100 err=1 data=%h", act.rv, act.err, act.data, e.data); else n_pass++;
        n_checks++; if (lat !== 2) $display("[TB] FAIL rsvd_latency: got %0d expected 2", lat); else n_pass++;
        n_checks++; if ((n_ld + n_en + n_rst) !== strobes0) $display("[TB] FAIL rsvd_no_strobes: got %0d pulses expected 0", n_ld + n_en + n_rst - strobes0); else n_pass++;
    endtask

    task automatic test_reset_op();
        exp_t act, e;
        int   lat, r0;
        bit   to;
        r0 = n_rst;
        run_op(3, OP_RST, 32'h0, 6'd9, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e || act.data !== 32'hFFFF_FFFF) $display("[TB] FAIL rstop_resp: got rv=%b data=%h expected rv=%b data=ffffffff", act.rv, act.data, e.rv); else n_pass++;
        n_checks++; if (lat !== 3 || (n_rst - r0) !== 1) $display("[TB] FAIL rstop_timing: got lat=%0d rst=%0d expected 3/1", lat, n_rst - r0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e, act;
        int   na = 0, nr = 0;
        int   rt[5];
        @(negedge clk);
        for (int i = 0; i < R; i++) issue(i, OP_DRAW, 32'h0, 6'd0, 1'b0);
        for (int k = 0; k < 40 && nr < 5; k++) begin
            #1;
            if (|resp_valid) begin
                act.rv = resp_valid; act.data = resp_data; act.err = resp_err;
                sb_pop(e);
                n_checks++; if (act !== e) $display("[TB] FAIL b2b_resp%0d: got rv=%b data=%h expected rv=%b data=%h", nr, act.rv, act.data, e.rv, e.data); else n_pass++;
                rt[nr] = cyc;
                nr++;
            end
            if ((|req_ready) && na < 5) begin
                n_checks++; if (req_ready !== (R'(1) << (na % R))) $display("[TB] FAIL b2b_accept%0d: got %b expected %b", na, req_ready, R'(1) << (na % R)); else n_pass++;
                push_expect(na % R, OP_DRAW, 32'h0, 6'd0, 1'b0);
                na++;
            end
            @(negedge clk);
            if (na == 5) req_valid = '0;
        end
        req_valid = '0;
        n_checks++; if (nr !== 5) $display("[TB] FAIL b2b_resp_count: got %0d expected 5", nr); else n_pass++;
        for (int i = 1; i < nr; i++) begin
            n_checks++; if ((rt[i] - rt[i-1]) !== 2) $display("[TB] FAIL b2b_spacing%0d: got %0d expected 2", i, rt[i] - rt[i-1]); else n_pass++;
        end
    endtask

    task automatic test_cfg_taps();
        exp_t act, e;
        int   lat;
        bit   to;
        fork
            run_op(1, OP_DRAW, 32'h0, 6'd10, 1'b0, act, lat, to);
            begin
                repeat (5) @(negedge clk);
                cfg_taps = 32'h0000_0001;
                cfg_we   = 1'b1;
                @(negedge clk);
                cfg_we   = 1'b0;
                taps_model = 32'h0000_0001;
                #1;
                n_checks++; if (busy !== 1'b1 || lfsr_taps !== 32'h8020_0003) $display("[TB] FAIL taps_in_flight: got busy=%b taps=%h expected 1/80200003", busy, lfsr_taps); else n_pass++;
            end
        join
        sb_pop(e);
        n_checks++; if (to || act !== e || lat !== 12) $display("[TB] FAIL taps_old_op: got data=%h lat=%0d expected data=%h lat=12", act.data, lat, e.data); else n_pass++;
        run_op(1, OP_DRAW, 32'h0, 6'd3, 1'b0, act, lat, to);
        sb_pop(e);
        n_checks++; if (to || act !== e) $display("[TB] FAIL taps_new_op: got data=%h expected %h", act.data, e.data); else n_pass++;
        n_checks++; if (lfsr_taps !== 32'h0000_0001) $display("[TB] FAIL taps_new_active: got %h expected 00000001", lfsr_taps); else n_pass++;
    endtask

    task automatic test_abort();
        exp_t act, e;
        bit   acc = 0, got = 0;
        int   t0 = 0, lat = -1;
        @(negedge clk);
        issue(1, OP_DRAW, 32'h0, 6'd20, 1'b0);
        for (int k = 0; k < 20 && !acc; k++) begin
            #1;
            if (req_ready[1]) acc = 1;
            @(negedge clk);
        end
        req_valid = '0;
        n_checks++; if (!acc) $display("[TB] FAIL abort_accept: got no accept expected accept"); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || lfsr_en !== 1'b0 || lfsr_rst !== 1'b1) $display("[TB] FAIL abort_state: got busy=%b en=%b rst=%b expected 0/0/1", busy, lfsr_en, lfsr_rst); else n_pass++;
        n_checks++; if (resp_valid !== '0) $display("[TB] FAIL abort_no_resp: got %b expected 0000", resp_valid); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        pred       = 32'hFFFF_FFFF;
        taps_model = 32'h8020_0003;
        #1;
        n_checks++; if (lfsr_taps !== 32'h8020_0003) $display("[TB] FAIL abort_taps_reset: got %h expected 80200003", lfsr_taps); else n_pass++;
        @(negedge clk);
        issue(0, OP_DRAW, 32'h0, 6'd0, 1'b0);
        issue(2, OP_DRAW, 32'h0, 6'd0, 1'b0);
        #1;
        n_checks++; if (req_ready !== 4'b0001) $display("[TB] FAIL abort_next_grant: got %b expected 0001", req_ready); else n_pass++;
        req_valid[2] = 1'b0;
        if (req_ready[0]) begin
            t0 = cyc;
            push_expect(0, OP_DRAW, 32'h0, 6'd0, 1'b0);
        end
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (|resp_valid) begin
                got = 1;
                act.rv = resp_valid; act.data = resp_data; act.err = resp_err;
                lat = cyc - t0;
            end else begin
                @(negedge clk);
            end
        end
        sb_pop(e);
        n_checks++; if (!got || act !== e || lat !== 2) $display("[TB] FAIL abort_followup: got rv=%b data=%h lat=%0d expected rv=%b data=%h lat=2", act.rv, act.data, lat, e.rv, e.data); else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_seed  = '0;
        req_steps = '0;
        req_half  = '0;
        cfg_we    = 1'b0;
        cfg_taps  = '0;
        #2;
        test_reset();
        test_draw();
        test_half();
        test_reserved();
        test_reset_op();
        test_back_to_back();
        test_cfg_taps();
        test_abort();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
